// File: rtl/dir_tx.sv
// Direction frame transmitter: sends {HEADER, {seq, dir}} as two back-to-back UART characters.
// Define DIR_TX_PARITY_EN to append an even-parity bit to each character (8E1 instead of 8N1).
module dir_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [2:0] dir,
  input  logic       en,
  input  logic       clr_ovr,
  output logic       tx,
  output logic       busy,
  output logic       sent,
  output logic       ovr,
  output logic [4:0] seq
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DIR_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t            state;
  logic              byte_sel;   // 0 = header character, 1 = payload character
  logic [2:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [7:0]        payload;
  logic [7:0]        cur_byte;
  logic              bit_done;

  assign cur_byte = byte_sel ? payload : HEADER;
  assign bit_done = (baud_cnt == BAUD_LAST);

  // tx is registered and always loaded with the value of the bit being entered,
  // so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      byte_sel <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      payload  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      sent     <= 1'b0;
      ovr      <= 1'b0;
      seq      <= '0;
    end else begin
      sent <= 1'b0;

      // A new overrun beats a simultaneous clear.
      if (send && en && busy)
        ovr <= 1'b1;
      else if (clr_ovr)
        ovr <= 1'b0;

      // NOTE: non-blocking assignments let the case below override this default
      // for the same register; the last assignment in program order wins.
      if (state != S_IDLE)
        baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (send && en && !busy) begin
            state    <= S_START;
            payload  <= {seq, dir};
            byte_sel <= 1'b0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            tx      <= cur_byte[0];
          end
        end

        S_DATA: begin
          if (bit_done) begin
            if (bit_cnt == 3'd7) begin
`ifdef DIR_TX_PARITY_EN
              state <= S_PAR;
              tx    <= ^cur_byte;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end
        end

`ifdef DIR_TX_PARITY_EN
        S_PAR: begin
          if (bit_done) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_done) begin
            if (!byte_sel) begin
              state    <= S_START;
              byte_sel <= 1'b1;
              tx       <= 1'b0;
            end else begin
              state    <= S_IDLE;
              byte_sel <= 1'b0;
              tx       <= 1'b1;
              busy     <= 1'b0;
              sent     <= 1'b1;
              seq      <= seq + 5'd1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dir_tx.sv
// Self-checking bench for dir_tx: a per-cycle queue model of the serial line plus
// literal frame checks; follows DIR_TX_PARITY_EN if it is defined.
module tb_dir_tx;

  localparam int CPB = 4;
`ifdef DIR_TX_PARITY_EN
  localparam int NB = 22;
  localparam logic [NB-1:0] F_BASIC = 22'b0_10100101_0_1_0_10000000_1_1;
  localparam logic [NB-1:0] F_OVR   = 22'b0_10100101_0_1_0_01010000_0_1;
  localparam logic [NB-1:0] F_2C    = 22'b0_10100101_0_1_0_00110100_1_1;
  localparam logic [NB-1:0] F_07    = 22'b0_10100101_0_1_0_11100000_1_1;
`else
  localparam int NB = 20;
  localparam logic [NB-1:0] F_BASIC = 20'b0_10100101_1_0_10000000_1;
  localparam logic [NB-1:0] F_OVR   = 20'b0_10100101_1_0_01010000_1;
  localparam logic [NB-1:0] F_2C    = 20'b0_10100101_1_0_00110100_1;
  localparam logic [NB-1:0] F_07    = 20'b0_10100101_1_0_11100000_1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send, en, clr_ovr;
  logic [2:0] dir;
  logic       tx, busy, sent, ovr;
  logic [4:0] seq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dir_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .send    (send),
    .dir     (dir),
    .en      (en),
    .clr_ovr (clr_ovr),
    .tx      (tx),
    .busy    (busy),
    .sent    (sent),
    .ovr     (ovr),
    .seq     (seq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted frame becomes a queue of per-cycle line values.
  logic       m_tx, m_busy, m_sent, m_ovr;
  logic [4:0] m_seq;
  bit         mq[$];

  task automatic push_bit(input bit v);
    repeat (CPB) mq.push_back(v);
  endtask

  task automatic push_char(input logic [7:0] b);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(b[i]);
`ifdef DIR_TX_PARITY_EN
    push_bit(^b);
`endif
    push_bit(1'b1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx = 1'b1; m_busy = 1'b0; m_sent = 1'b0; m_ovr = 1'b0; m_seq = '0;
      mq.delete();
    end else begin
      m_sent = 1'b0;
      if (m_busy && send && en) m_ovr = 1'b1;
      else if (clr_ovr)         m_ovr = 1'b0;
      if (m_busy) begin
        if (mq.size() > 0) m_tx = mq.pop_front();
        else begin
          m_tx = 1'b1; m_busy = 1'b0; m_sent = 1'b1; m_seq = m_seq + 5'd1;
        end
      end else if (send && en) begin
        push_char(8'hA5);
        push_char({m_seq, dir});
        m_tx   = mq.pop_front();
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("tx",   tx,   m_tx);
      check("busy", busy, m_busy);
      check("sent", sent, m_sent);
      check("ovr",  ovr,  m_ovr);
      check("seq",  seq,  m_seq);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Sends one frame, samples tx mid-bit, returns the bits and the strobe-to-sent latency.
  // A second send is injected at cycle ovr_at when ovr_at >= 0.
  task automatic run_frame(input logic [2:0] d, input int ovr_at,
                           output logic [NB-1:0] bits, output int cyc);
    int j = 0;
    bits = '0;
    cyc  = -1;
    wait_idle();
    @(negedge clk);
    send = 1'b1; dir = d;
    @(negedge clk);
    send = 1'b0;
    dir  = 3'($urandom);
    while (j < 200) begin
      send = (j == ovr_at);
      if ((j % CPB) == 1 && (j / CPB) < NB) bits[NB-1-(j/CPB)] = tx;
      if (sent) begin cyc = j; break; end
      @(negedge clk);
      j++;
    end
    send = 1'b0;
    if (cyc < 0) check("frame_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] bits;
    int cyc;

    rst_n = 1'b0; send = 1'b0; en = 1'b1; dir = '0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",   tx,   1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_sent", sent, 1'b0);
    check("rst_ovr",  ovr,  1'b0);
    check("rst_seq",  seq,  5'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame
    run_frame(3'd1, -1, bits, cyc);
    check("basic_bits", bits, F_BASIC);
    check("basic_len",  cyc,  NB * CPB);
    check("basic_seq",  seq,  5'd1);
    check("basic_ovr",  ovr,  1'b0);

    // Overrun: second send 10 cycles in is dropped
    run_frame(3'd2, 10, bits, cyc);
    check("ovr_bits", bits, F_OVR);
    check("ovr_len",  cyc,  NB * CPB);
    check("ovr_set",  ovr,  1'b1);
    check("ovr_seq",  seq,  5'd2);
    @(negedge clk); clr_ovr = 1'b1;
    @(negedge clk); clr_ovr = 1'b0;
    check("ovr_clr", ovr, 1'b0);

    // Disabled: send ignored
    en = 1'b0;
    @(negedge clk); send = 1'b1;
    @(negedge clk); send = 1'b0;
    repeat (20) @(negedge clk);
    check("dis_tx",   tx,   1'b1);
    check("dis_busy", busy, 1'b0);
    check("dis_seq",  seq,  5'd2);
    check("dis_ovr",  ovr,  1'b0);
    en = 1'b1;

    // Payload 8'h2C at seq 5
    repeat (3) run_frame(3'd0, -1, bits, cyc);
    check("seq5", seq, 5'd5);
    run_frame(3'd4, -1, bits, cyc);
    check("p2c_bits", bits, F_2C);
    check("p2c_len",  cyc,  NB * CPB);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      send    = ($urandom_range(0, 15) == 0);
      en      = ($urandom_range(0, 7) != 0);
      dir     = 3'($urandom);
      clr_ovr = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    send = 1'b0; en = 1'b1; clr_ovr = 1'b0;
    wait_idle();

    // Sequence wrap from a clean reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 31; i++) run_frame(3'($urandom), -1, bits, cyc);
    check("seq31", seq, 5'd31);
    run_frame(3'($urandom), -1, bits, cyc);
    check("seq_wrap", seq, 5'd0);

    // Reset in the middle of DATA
    wait_idle();
    @(negedge clk); send = 1'b1; dir = 3'd5;
    @(negedge clk); send = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx",   tx,   1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(3'd7, -1, bits, cyc);
    check("post_rst_bits", bits, F_07);
    check("post_rst_seq",  seq,  5'd1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
